la_wb_initiator: RTL and testbench
==================================

LA_WB_INITIATOR -- requirements
Module: la_wb_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255, sets the maximum bus-wait cycles before a transaction is abandoned (legal range 1..65535).
REQ-002 clock  input  1  single clock; all logic SHALL be on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_req  input  1  request toggle from logic-analyzer probes; each level change is one command.
REQ-005 cmd_we  input  1  1 = write, 0 = read.
REQ-006 cmd_sel  input  4  byte selects.
REQ-007 cmd_adr  input  32  byte address.
REQ-008 cmd_dat  input  32  write data.
REQ-009 cmd_ack  output  1  completion toggle; a change in level means the response is valid.
REQ-010 rsp_dat  output  32  read data of the last completed read.
REQ-011 rsp_err  output  1  1 = last command timed out.
REQ-012 busy  output  1  high from command acceptance until cmd_ack toggles.
REQ-013 txn_count  output  16  count of completed commands, including timed-out ones.
REQ-014 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone initiator controls.
REQ-015 wbm_sel_o  output  4; wbm_adr_o  output  32; wbm_dat_o  output  32.
REQ-016 wbm_ack_i  input  1; wbm_dat_i  input  32  Wishbone responder returns.

Function
REQ-017 cmd_req SHALL pass through a 2-flop synchronizer; a pending command exists when the synchronized value differs from the internal req_seen flag.
REQ-018 States SHALL be IDLE, BUS and DONE.
REQ-019 In IDLE with a pending command, the block SHALL latch cmd_* into the wbm_* registers, set req_seen to the synchronized value, assert busy, clear the wait counter and enter BUS.
REQ-020 Latency: wbm_cyc_o and wbm_stb_o SHALL be high after the 3rd rising edge, counting the first edge that samples the new cmd_req level as edge 1.
REQ-021 In BUS, cyc and stb SHALL stay high and all wbm_* outputs SHALL stay stable until wbm_ack_i is sampled high; this is a classic single-transfer cycle, with no pipelining and no bursts.
REQ-022 On a sampled wbm_ack_i in BUS, on the same edge:
- cyc and stb SHALL drop;
- for a read, wbm_dat_i SHALL be captured into rsp_dat;
- rsp_err SHALL be cleared;
- the state SHALL move to DONE.
REQ-023 On writes, rsp_dat SHALL be unchanged.
REQ-024 DONE SHALL last exactly one cycle, then:
- cmd_ack toggles;
- busy drops;
- txn_count increments, wrapping from 0xFFFF to 0x0000;
- the state returns to IDLE.
REQ-025 wbm_ack_i SHALL be ignored in IDLE and DONE.
REQ-026 cmd_* changes while busy SHALL NOT affect the bus.
REQ-027 A single cmd_req toggle while busy SHALL be held pending and accepted on the cycle after return to IDLE.
REQ-028 Two toggles while busy net to no command; the host SHALL wait for cmd_ack before toggling again.
REQ-029 wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o SHALL hold their last values in IDLE.

Reset
REQ-030 Assertion of reset_n low SHALL immediately force:
- state IDLE;
- wbm_cyc_o, wbm_stb_o, wbm_we_o, busy, rsp_err and cmd_ack to 0;
- wbm_sel_o to 0x0;
- wbm_adr_o, wbm_dat_o and rsp_dat to 0x00000000;
- txn_count to 0x0000;
- req_seen and both synchronizer flops to 0.
REQ-031 Reset asserted mid-BUS SHALL drop cyc and stb asynchronously, with no completion toggle.
REQ-032 After reset release, a cmd_req already high SHALL count as one pending command.
REQ-033 Reset deassertion is synchronized externally; no internal reset synchronizer is required.

Configuration
REQ-034 Macro LA_WB_INITIATOR_TIMEOUT_EN, when defined, SHALL enable a 16-bit wait counter in BUS.
- The counter increments each BUS cycle without an ack.
- When it equals TIMEOUT, cyc and stb SHALL drop, rsp_err SHALL be set to 1 and rsp_dat SHALL be unchanged.
- The state SHALL then move to DONE.
- An ack sampled on the same edge as expiry SHALL win: normal completion with rsp_err 0.
REQ-035 Without the macro, BUS SHALL wait indefinitely, rsp_err SHALL be tied 0, and no counter logic SHALL be present.

Verification
REQ-036 Write: toggle cmd_req with we=1, adr=0x30000004, dat=0xA5A5A5A5, sel=0xF; responder acks after 2 cycles -> cyc and stb high from edge 3 with matching outputs for exactly 3 cycles, then cmd_ack toggles, txn_count=1, rsp_dat unchanged.
REQ-037 Read: we=0, adr=0x30000010; responder returns 0x12345678 with a zero-wait ack -> rsp_dat=0x12345678, rsp_err=0, cmd_ack toggles 2 edges after the ack.
REQ-038 Timeout (macro defined, TIMEOUT=4): responder never acks -> cyc and stb drop after 4 BUS cycles, rsp_err=1, cmd_ack toggles; the next successful command clears rsp_err.
REQ-039 Pending and reset:
- A toggle issued mid-BUS is accepted the cycle after IDLE re-entry.
- reset_n pulsed low mid-BUS -> cyc, stb and cmd_ack are 0 immediately and txn_count=0x0000.
REQ-040 Wrap and ack-ignore:
- Preload 0xFFFF completions, then one more -> txn_count=0x0000.
- A spurious wbm_ack_i in IDLE causes no state or output change.

Source files
------------

// File: rtl/la_wb_initiator_if.sv
`default_nettype none
// ============================================================================
// la_wb_initiator_if : Wishbone classic single-transfer initiator bus bundle
// Revision: 1.0
// ============================================================================
interface la_wb_initiator_if;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface
`default_nettype wire

// File: rtl/la_wb_initiator.sv
`default_nettype none
// ============================================================================
// la_wb_initiator : toggle-handshake command port to Wishbone classic initiator
// Optional bus-wait timeout enabled by macro LA_WB_INITIATOR_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module la_wb_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cmd_req,
  input  logic              cmd_we,
  input  logic [3:0]        cmd_sel,
  input  logic [31:0]       cmd_adr,
  input  logic [31:0]       cmd_dat,
  output logic              cmd_ack,
  output logic [31:0]       rsp_dat,
  output logic              rsp_err,
  output logic              busy,
  output logic [15:0]       txn_count,
  la_wb_initiator_if.master bus
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_bus  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_req_seen;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_cmd_ack;
  logic [31:0] r_rsp_dat;
  logic [15:0] r_txn_count;
  logic        w_pending;
  logic        w_accept;
  logic        w_bus_ack;
  logic        w_done;
  logic        w_cyc;
  logic        w_busy;
  logic        w_timeout;

  assign w_pending = r_sync2 ^ r_req_seen;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_pending) w_state_next = c_st_bus;
      c_st_bus:  if (bus.wbm_ack_i || w_timeout) w_state_next = c_st_done;
      c_st_done: w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_cyc     = (r_state == c_st_bus);
    w_busy    = (r_state != c_st_idle);
    w_accept  = (r_state == c_st_idle) && w_pending;
    w_bus_ack = (r_state == c_st_bus) && bus.wbm_ack_i;
    w_done    = (r_state == c_st_done);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_req_seen  <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_adr       <= 32'h0000_0000;
      r_dat       <= 32'h0000_0000;
      r_cmd_ack   <= 1'b0;
      r_rsp_dat   <= 32'h0000_0000;
      r_txn_count <= 16'h0000;
    end else begin
      r_sync1 <= cmd_req;
      r_sync2 <= r_sync1;
      // Bus fields only load on acceptance, so they hold through BUS and IDLE.
      if (w_accept) begin
        r_req_seen <= r_sync2;
        r_we       <= cmd_we;
        r_sel      <= cmd_sel;
        r_adr      <= cmd_adr;
        r_dat      <= cmd_dat;
      end
      if (w_bus_ack && !r_we) begin
        r_rsp_dat <= bus.wbm_dat_i;
      end
      if (w_done) begin
        r_cmd_ack   <= ~r_cmd_ack;
        r_txn_count <= r_txn_count + 16'd1;
      end
    end
  end

`ifdef LA_WB_INITIATOR_TIMEOUT_EN
  localparam logic [15:0] c_timeout = 16'(TIMEOUT);

  logic [15:0] r_wait_cnt;
  logic [15:0] w_wait_inc;
  logic        r_rsp_err;

  assign w_wait_inc = r_wait_cnt + 16'd1;
  // An ack on the expiry edge takes priority over the timeout.
  assign w_timeout  = (r_state == c_st_bus) && !bus.wbm_ack_i && (w_wait_inc == c_timeout);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 16'h0000;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wait_cnt <= 16'h0000;
      end else if ((r_state == c_st_bus) && !bus.wbm_ack_i) begin
        r_wait_cnt <= w_wait_inc;
      end
      if (w_bus_ack) begin
        r_rsp_err <= 1'b0;
      end else if (w_timeout) begin
        r_rsp_err <= 1'b1;
      end
    end
  end

  assign rsp_err = r_rsp_err;
`else
  localparam logic [15:0] c_unused_timeout = 16'(TIMEOUT);

  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  assign bus.wbm_cyc_o = w_cyc;
  assign bus.wbm_stb_o = w_cyc;
  assign bus.wbm_we_o  = r_we;
  assign bus.wbm_sel_o = r_sel;
  assign bus.wbm_adr_o = r_adr;
  assign bus.wbm_dat_o = r_dat;
  assign cmd_ack       = r_cmd_ack;
  assign rsp_dat       = r_rsp_dat;
  assign busy          = w_busy;
  assign txn_count     = r_txn_count;

endmodule
`default_nettype wire

// File: tb/tb_la_wb_initiator.sv
`default_nettype none
// ============================================================================
// tb_la_wb_initiator : self-checking bench for la_wb_initiator
// Revision: 1.0
// ============================================================================
module tb_la_wb_initiator;
  localparam int unsigned T = 4;
`ifdef LA_WB_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cmd_req;
  logic        cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        cmd_ack;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        busy;
  logic [15:0] txn_count;

  la_wb_initiator_if bus();

  la_wb_initiator #(.TIMEOUT(T)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_req(cmd_req), .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
    .cmd_ack(cmd_ack), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy), .txn_count(txn_count),
    .bus(bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Responder: acks after rs_wait cycles of cyc, optionally never, optionally spurious in idle.
  int          rs_wait = 0;
  int          rs_cnt = 0;
  bit          rs_never = 1'b0;
  bit          rs_spurious = 1'b0;
  logic [31:0] rs_data = 32'h0;

  always @(negedge clock) begin
    if (bus.wbm_cyc_o) begin
      if (!rs_never && rs_cnt >= rs_wait) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = rs_data;
      end else begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = $urandom;
      end
      rs_cnt++;
    end else begin
      rs_cnt = 0;
      bus.wbm_ack_i = rs_spurious;
      bus.wbm_dat_i = $urandom;
    end
  end

  // Reference state of the command port
  logic        m_ack = 1'b0;
  logic [15:0] m_cnt = 16'h0;
  logic [31:0] m_dat = 32'h0;
  logic        m_err = 1'b0;

  // Fields used for toggles issued while busy
  logic        b_we;
  logic [3:0]  b_sel;
  logic [31:0] b_adr;
  logic [31:0] b_dat;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge. lead = negedges until cyc is expected high.
  // mid = number of extra cmd_req toggles issued during BUS (at BUS cycles 1 and 2).
  task automatic run_txn(input bit we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input int wt, input bit never,
                         input logic [31:0] rdata, input bit toggle, input int lead, input int mid);
    bit timed;
    int n;
    timed = TO_EN && (never || wt >= int'(T));
    n = timed ? int'(T) : wt + 1;
    rs_wait = wt; rs_never = never; rs_data = rdata;
    if (toggle) begin
      cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
      cmd_req = ~cmd_req;
    end
    for (int k = 1; k < lead; k++) begin
      @(negedge clock);
      chk1("pre_cyc", bus.wbm_cyc_o, 1'b0);
      chk1("pre_busy", busy, 1'b0);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      chk1("bus_cyc", bus.wbm_cyc_o, 1'b1);
      chk1("bus_stb", bus.wbm_stb_o, 1'b1);
      chk1("bus_we", bus.wbm_we_o, we);
      chk32("bus_sel", 32'(bus.wbm_sel_o), 32'(sel));
      chk32("bus_adr", bus.wbm_adr_o, adr);
      chk32("bus_dat", bus.wbm_dat_o, dat);
      chk1("bus_busy", busy, 1'b1);
      if ((mid >= 1 && k == 1) || (mid == 2 && k == 2)) begin
        cmd_we = b_we; cmd_sel = b_sel; cmd_adr = b_adr; cmd_dat = b_dat;
        cmd_req = ~cmd_req;
      end
    end
    @(negedge clock);
    chk1("done_cyc", bus.wbm_cyc_o, 1'b0);
    chk1("done_busy", busy, 1'b1);
    chk1("done_ack", cmd_ack, m_ack);
    m_ack = ~m_ack;
    m_cnt = m_cnt + 16'd1;
    if (timed) begin
      m_err = 1'b1;
    end else begin
      m_err = 1'b0;
      if (!we) m_dat = rdata;
    end
    @(negedge clock);
    chk1("end_ack", cmd_ack, m_ack);
    chk1("end_busy", busy, 1'b0);
    chk1("end_cyc", bus.wbm_cyc_o, 1'b0);
    chk32("end_rsp_dat", rsp_dat, m_dat);
    chk1("end_rsp_err", rsp_err, m_err);
    chk32("end_txn_count", 32'(txn_count), 32'(m_cnt));
  endtask

  typedef struct {
    bit          we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          wt;
    logic [31:0] rdata;
    logic [31:0] exp_rsp;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_A5A5, 2, 32'h5555_AAAA, 32'h0000_0000, 16'd1};
    vecs[1] = '{1'b0, 4'hF, 32'h3000_0010, 32'h0000_0000, 0, 32'h1234_5678, 32'h1234_5678, 16'd2};
    vecs[2] = '{1'b1, 4'h3, 32'h3000_0020, 32'h0000_FFFF, 1, 32'h7777_7777, 32'h1234_5678, 16'd3};
    vecs[3] = '{1'b0, 4'hF, 32'h3000_0024, 32'h0000_0000, 3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd4};

    reset_n = 1'b0; cmd_req = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0;
    cmd_adr = 32'h0; cmd_dat = 32'h0;
    b_we = 1'b0; b_sel = 4'hC; b_adr = 32'h3000_0040; b_dat = 32'h1111_2222;
    repeat (3) @(negedge clock);
    chk1("rst_cyc", bus.wbm_cyc_o, 1'b0);
    chk1("rst_stb", bus.wbm_stb_o, 1'b0);
    chk1("rst_we", bus.wbm_we_o, 1'b0);
    chk32("rst_sel", 32'(bus.wbm_sel_o), 32'h0);
    chk32("rst_adr", bus.wbm_adr_o, 32'h0);
    chk32("rst_dat", bus.wbm_dat_o, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ack", cmd_ack, 1'b0);
    chk32("rst_rsp_dat", rsp_dat, 32'h0);
    chk1("rst_rsp_err", rsp_err, 1'b0);
    chk32("rst_txn_count", 32'(txn_count), 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 4; i++) begin
      run_txn(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, vecs[i].wt, 1'b0,
              vecs[i].rdata, 1'b1, 3, 0);
      chk32("vec_rsp_dat", rsp_dat, vecs[i].exp_rsp);
      chk32("vec_txn_count", 32'(txn_count), 32'(vecs[i].exp_cnt));
      chk1("vec_rsp_err", rsp_err, 1'b0);
    end

    for (int i = 0; i < 16; i++) begin
      run_txn(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 4)), 1'b0, $urandom, 1'b1, 3, 0);
    end

    // Toggle mid-BUS: held pending and accepted right after IDLE re-entry
    run_txn(1'b1, 4'hF, 32'h3000_0030, 32'hCAFE_F00D, 2, 1'b0, 32'h0, 1'b1, 3, 1);
    run_txn(b_we, b_sel, b_adr, b_dat, 1, 1'b0, 32'h0BAD_CAFE, 1'b0, 1, 0);

    // Two toggles while busy cancel out
    run_txn(1'b1, 4'h1, 32'h3000_0050, 32'h0000_0001, 3, 1'b0, 32'h0, 1'b1, 3, 2);
    repeat (5) begin
      @(negedge clock);
      chk1("dbl_cyc", bus.wbm_cyc_o, 1'b0);
      chk1("dbl_busy", busy, 1'b0);
    end

    // Spurious ack in IDLE right after a read
    run_txn(1'b0, 4'hF, 32'h3000_0060, 32'h0, 0, 1'b0, 32'h600D_D00D, 1'b1, 3, 0);
    rs_spurious = 1'b1;
    repeat (4) begin
      @(negedge clock);
      chk1("spur_cyc", bus.wbm_cyc_o, 1'b0);
      chk1("spur_busy", busy, 1'b0);
      chk1("spur_ack", cmd_ack, m_ack);
      chk32("spur_rsp_dat", rsp_dat, m_dat);
      chk1("spur_rsp_err", rsp_err, m_err);
      chk32("spur_txn_count", 32'(txn_count), 32'(m_cnt));
    end
    rs_spurious = 1'b0;
    @(negedge clock);

    if (TO_EN) begin
      run_txn(1'b0, 4'hF, 32'h3000_0070, 32'h0, 0, 1'b1, 32'hFFFF_0000, 1'b1, 3, 0);
      chk1("to_err_set", rsp_err, 1'b1);
      run_txn(1'b1, 4'hF, 32'h3000_0074, 32'h1357_9BDF, 0, 1'b0, 32'h0, 1'b1, 3, 0);
      chk1("to_err_clr", rsp_err, 1'b0);
    end

    // Wrap: preload the completion counter to 0xFFFF while idle
    dut.r_txn_count = 16'hFFFF;
    m_cnt = 16'hFFFF;
    run_txn(1'b1, 4'hF, 32'h3000_0080, 32'h0000_00FF, 0, 1'b0, 32'h0, 1'b1, 3, 0);
    chk32("wrap_txn_count", 32'(txn_count), 32'h0);

    // Reset mid-BUS, with cmd_req held high across release
    rs_wait = 20; rs_never = 1'b0;
    cmd_we = 1'b1; cmd_sel = 4'hF; cmd_adr = 32'h3000_0090; cmd_dat = 32'h0;
    cmd_req = ~cmd_req;
    repeat (4) @(negedge clock);
    chk1("prerst_cyc", bus.wbm_cyc_o, 1'b1);
    reset_n = 1'b0;
    cmd_we = 1'b0; cmd_sel = 4'h5; cmd_adr = 32'h3000_00A0; cmd_dat = 32'h0;
    cmd_req = 1'b1;
    #1;
    chk1("midrst_cyc", bus.wbm_cyc_o, 1'b0);
    chk1("midrst_stb", bus.wbm_stb_o, 1'b0);
    chk1("midrst_ack", cmd_ack, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk32("midrst_txn_count", 32'(txn_count), 32'h0);
    m_ack = 1'b0; m_cnt = 16'h0; m_dat = 32'h0; m_err = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    run_txn(1'b0, 4'h5, 32'h3000_00A0, 32'h0, 1, 1'b0, 32'h2468_ACE0, 1'b0, 3, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
